mc_control_unit: RTL

- Multicycle successor to the single-cycle MIPS control unit.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Waits on the instruction-memory and data-memory hit handshakes.
- Traps overflow, and can time out a stalled memory access.
- Sits between the datapath (which provides the IR fields and ALU flags) and the memory arbiter. It drives all datapath enables and selects.

---
 rtl/mc_control_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control unit: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB,
// waits on the imem/dmem hit handshakes, traps signed overflow, and can time out stalled accesses.
module mc_control_unit #(
  parameter int ALU_OP_W    = 4,
  parameter bit HALT_ON_OVF = 1'b1,
  parameter int WAIT_LIMIT  = 0
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                ihit,
  input  logic                dhit,
  input  logic                zero,
  input  logic                overflow,
  output logic                imemREN,
  output logic                dmemREN,
  output logic                dmemWEN,
  output logic                ir_wen,
  output logic                pc_wen,
  output logic [1:0]          pc_src,
  output logic                reg_wen,
  output logic [1:0]          reg_dst,
  output logic [1:0]          memtoreg,
  output logic [1:0]          alu_srcb,
  output logic                ext_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                halt,
  output logic                err,
  output logic [2:0]          state_o
);
  // ALU encodings (cpu_types_pkg aluop_t order)
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(9);

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010, OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111, OP_LW   = 6'b100011, OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] F_SLL = 6'b000000, F_SRL  = 6'b000010, F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011, F_AND = 6'b100100, F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110, F_NOR  = 6'b100111, F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALTED = 3'd5
  } state_t;

  state_t               state, next_state;
  logic [CNT_W-1:0]     cnt;
  logic [ALU_OP_W-1:0]  d_op;
  logic [1:0]           d_srcb;
  logic                 d_ext, r_alu, r_jr, i_alu, ovf_op;
  logic                 is_lw, is_sw, is_lui, stall, timeout;

  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_lui  = (opcode == OP_LUI);
  assign state_o = state;

  // A stall cycle that would bring the counter up to the limit is a timeout; a hit always wins.
  assign stall   = ((state == FETCH) && !ihit) || ((state == MEM) && !dhit);
  assign timeout = stall && (WAIT_LIMIT > 0) && (int'(cnt) + 1 >= WAIT_LIMIT);

  // Instruction decode into ALU controls and instruction classes
  always_comb begin
    d_op = ALU_SLL; d_srcb = 2'b00; d_ext = 1'b0;
    r_alu = 1'b0; r_jr = 1'b0; i_alu = 1'b0; ovf_op = 1'b0;
    if (opcode == OP_RTYPE) begin
      r_alu = 1'b1;
      case (funct)
        F_SLL:  begin d_op = ALU_SLL; d_srcb = 2'b10; end
        F_SRL:  begin d_op = ALU_SRL; d_srcb = 2'b10; end
        F_ADD:  begin d_op = ALU_ADD; ovf_op = 1'b1; end
        F_ADDU: d_op = ALU_ADD;
        F_SUB:  begin d_op = ALU_SUB; ovf_op = 1'b1; end
        F_SUBU: d_op = ALU_SUB;
        F_AND:  d_op = ALU_AND;
        F_OR:   d_op = ALU_OR;
        F_XOR:  d_op = ALU_XOR;
        F_NOR:  d_op = ALU_NOR;
        F_SLT:  d_op = ALU_SLT;
        F_SLTU: d_op = ALU_SLTU;
        F_JR:   begin r_alu = 1'b0; r_jr = 1'b1; end
        default: r_alu = 1'b0;
      endcase
    end else begin
      case (opcode)
        OP_ADDI:  begin i_alu = 1'b1; d_op = ALU_ADD;  d_srcb = 2'b01; d_ext = 1'b1; ovf_op = 1'b1; end
        OP_ADDIU: begin i_alu = 1'b1; d_op = ALU_ADD;  d_srcb = 2'b01; d_ext = 1'b1; end
        OP_SLTI:  begin i_alu = 1'b1; d_op = ALU_SLT;  d_srcb = 2'b01; d_ext = 1'b1; end
        OP_SLTIU: begin i_alu = 1'b1; d_op = ALU_SLTU; d_srcb = 2'b01; d_ext = 1'b1; end
        OP_ANDI:  begin i_alu = 1'b1; d_op = ALU_AND;  d_srcb = 2'b01; end
        OP_ORI:   begin i_alu = 1'b1; d_op = ALU_OR;   d_srcb = 2'b01; end
        OP_XORI:  begin i_alu = 1'b1; d_op = ALU_XOR;  d_srcb = 2'b01; end
        OP_LW, OP_SW: begin d_op = ALU_ADD; d_srcb = 2'b01; d_ext = 1'b1; end
        OP_BEQ, OP_BNE: d_op = ALU_SUB;
        default: ;
      endcase
    end
  end

  // Per-state datapath controls and next-state selection
  always_comb begin
    imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; ir_wen = 1'b0; pc_wen = 1'b0;
    pc_src = 2'b00; reg_wen = 1'b0; reg_dst = 2'b00; memtoreg = 2'b00;
    alu_srcb = 2'b00; ext_src = 1'b0; alu_op = ALU_SLL;
    next_state = state;
    case (state)
      FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          ir_wen = 1'b1; pc_wen = 1'b1; next_state = DECODE;
        end else if (timeout) next_state = HALTED;
      end
      DECODE: next_state = (opcode == OP_HALT) ? HALTED : EXEC;
      EXEC: begin
        alu_op = d_op; alu_srcb = d_srcb; ext_src = d_ext;
        next_state = FETCH;
        if (r_alu || i_alu || is_lui)
          next_state = (HALT_ON_OVF && ovf_op && overflow) ? HALTED : WB;
        if (is_lw || is_sw) next_state = MEM;
        if (r_jr) begin pc_wen = 1'b1; pc_src = 2'b11; end
        if (opcode == OP_J) begin pc_wen = 1'b1; pc_src = 2'b10; end
        if (opcode == OP_JAL) begin
          pc_wen = 1'b1; pc_src = 2'b10; reg_wen = 1'b1; reg_dst = 2'b10; memtoreg = 2'b10;
        end
        if (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero)) begin
          pc_wen = 1'b1; pc_src = 2'b01;
        end
      end
      MEM: begin
        alu_op = d_op; alu_srcb = d_srcb; ext_src = d_ext;
        dmemREN = is_lw; dmemWEN = is_sw;
        if (dhit) next_state = is_lw ? WB : FETCH;
        else if (timeout) next_state = HALTED;
      end
      WB: begin
        alu_op = d_op; alu_srcb = d_srcb; ext_src = d_ext;
        reg_wen = 1'b1;
        reg_dst = r_alu ? 2'b01 : 2'b00;
        memtoreg = is_lw ? 2'b01 : (is_lui ? 2'b11 : 2'b00);
        next_state = FETCH;
      end
      HALTED: next_state = HALTED;
      default: next_state = FETCH;
    endcase
  end

  // State, sticky halt/err and the stall counter (cleared on any state change or hit)
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= FETCH; halt <= 1'b0; err <= 1'b0; cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state == HALTED) halt <= 1'b1;
      if (timeout) err <= 1'b1;
      if ((next_state != state) || !stall) cnt <= '0;
      else if ((WAIT_LIMIT > 0) && (int'(cnt) < WAIT_LIMIT)) cnt <= cnt + CNT_W'(1);
    end
  end
endmodule
